// File: rtl/n64_pkg.sv
// Shared constants, timing multipliers and FSM state type for the N64 controller responder.
// N64_RESET_CMD_EN: when defined, command 0xFF is answered like the identity command.
package n64_pkg;

    localparam logic [7:0] CMD_IDENTITY = 8'h00;
    localparam logic [7:0] CMD_POLL     = 8'h01;
    localparam logic [7:0] CMD_RESET    = 8'hFF;

    localparam logic [7:0]  ID_BYTE0 = 8'h05;
    localparam logic [7:0]  ID_BYTE1 = 8'h00;
    localparam logic [7:0]  ID_BYTE2 = 8'h02;
    localparam logic [23:0] ID_REPLY = {ID_BYTE0, ID_BYTE1, ID_BYTE2};

    localparam int unsigned T_1US    = 1;
    localparam int unsigned T_2US    = 2;
    localparam int unsigned T_3US    = 3;
    localparam int unsigned T_BIT_US = 4;

    localparam logic [5:0] ID_BITS   = 6'd24;
    localparam logic [5:0] POLL_BITS = 6'd32;

    typedef enum logic [2:0] {
        IDLE,
        RX_BITS,
        RX_STOP,
        TURNAROUND,
        TX,
        TX_STOP
    } state_t;

    function automatic logic is_identity_cmd(input logic [7:0] cmd);
`ifdef N64_RESET_CMD_EN
        return (cmd == CMD_IDENTITY) || (cmd == CMD_RESET);
`else
        return cmd == CMD_IDENTITY;
`endif
    endfunction

endpackage

// File: rtl/n64_controller_responder_if.sv
// Line and host-side signals of the responder; slave = responder, master = line/host side.
// Pure wiring: no latency, no backpressure.
interface n64_controller_responder_if;
    logic        n64d_in;
    logic        n64d_oe;
    logic [31:0] button_data;
    logic [7:0]  cmd_byte;
    logic        cmd_valid;
    logic        tx_busy;

    modport slave (
        input  n64d_in,
        input  button_data,
        output n64d_oe,
        output cmd_byte,
        output cmd_valid,
        output tx_busy
    );

    modport master (
        output n64d_in,
        output button_data,
        input  n64d_oe,
        input  cmd_byte,
        input  cmd_valid,
        input  tx_busy
    );
endinterface

// File: rtl/n64_bit_tx.sv
// One N64 bit cell (4 us) or stop pulse (2 us low); oe rises the edge after start.
// No backpressure: a start while busy restarts the cell; done marks the last cycle.
module n64_bit_tx
    import n64_pkg::*;
#(
    parameter int unsigned CYCLES_PER_US = 50
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic start,
    input  logic bit_val,
    input  logic stop_mode,
    output logic oe,
    output logic done
);
    localparam int unsigned CW = 16;
    localparam logic [CW-1:0] LOW_1    = CW'(T_1US * CYCLES_PER_US);
    localparam logic [CW-1:0] LOW_2    = CW'(T_2US * CYCLES_PER_US);
    localparam logic [CW-1:0] LOW_3    = CW'(T_3US * CYCLES_PER_US);
    localparam logic [CW-1:0] BIT_LAST = CW'(T_BIT_US * CYCLES_PER_US - 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] low_len;
    logic [CW-1:0] low_len_nxt;
    logic          active;
    logic          is_stop;

    always_comb begin
        low_len_nxt = bit_val ? LOW_1 : LOW_3;
        if (stop_mode) begin
            low_len_nxt = LOW_2;
        end
    end

    // The stop pulse ends on its release cycle; data cells run the full bit time.
    assign done = active && (cnt == (is_stop ? (low_len - 1'b1) : BIT_LAST));

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            active  <= 1'b0;
            oe      <= 1'b0;
            cnt     <= '0;
            low_len <= '0;
            is_stop <= 1'b0;
        end else if (start) begin
            active  <= 1'b1;
            oe      <= 1'b1;
            cnt     <= '0;
            low_len <= low_len_nxt;
            is_stop <= stop_mode;
        end else if (active) begin
            cnt <= cnt + 1'b1;
            if (cnt == low_len - 1'b1) begin
                oe <= 1'b0;
            end
            if (done) begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/n64_controller_responder.sv
// N64 controller emulation: decodes console command bytes, answers identity/poll (N64_RESET_CMD_EN adds 0xFF).
// Input decode lags the line by 3 cycles; line timing is fixed, so there is no backpressure.
module n64_controller_responder
    import n64_pkg::*;
#(
    parameter int unsigned CYCLES_PER_US   = 50,
    parameter int unsigned IDLE_TIMEOUT_US = 5
) (
    input logic                       sys_clk,
    input logic                       sys_rst,
    n64_controller_responder_if.slave bus
);
    localparam int unsigned CW       = 16;
    localparam int unsigned SYNC_LAT = 3;
    // Sample/turnaround counts are shortened by the synchronizer + edge-detect lag so
    // they land 2 us after the real line edge.
    localparam logic [CW-1:0] SAMPLE_AT    = CW'(T_2US * CYCLES_PER_US - SYNC_LAT);
    localparam logic [CW-1:0] TURN_LAST    = CW'(T_2US * CYCLES_PER_US - SYNC_LAT - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(IDLE_TIMEOUT_US * CYCLES_PER_US - 1);

    state_t        state, state_nxt;
    logic          sync1, sync2, sync_prev;
    logic          fall, rise, rx_gate, rx_active, timeout;
    logic [CW-1:0] cnt, high_cnt;
    logic          bit_phase;
    logic [2:0]    rx_cnt;
    logic [7:0]    rx_sr;
    logic          stop_seen;
    logic [7:0]    cmd_byte_q;
    logic          cmd_valid_q;
    logic [31:0]   tx_sr;
    logic [5:0]    tx_left;
    logic [31:0]   reply_word;
    logic [5:0]    reply_len;
    logic          supported;

    logic tx_start, tx_bit, tx_stop_mode, tx_done, tx_oe;
    logic load_reply, shift_reply;
    logic rx_enter, rx_arm, rx_sample, stop_fall, cmd_commit;

    assign rx_gate   = (state != TX) && (state != TX_STOP);
    assign fall      = rx_gate && sync_prev && !sync2;
    assign rise      = rx_gate && !sync_prev && sync2;
    assign rx_active = (state == RX_BITS) || (state == RX_STOP);
    assign timeout   = sync2 && (high_cnt >= TIMEOUT_LAST);
    assign supported = is_identity_cmd(cmd_byte_q) || (cmd_byte_q == CMD_POLL);

    always_comb begin
        if (cmd_byte_q == CMD_POLL) begin
            reply_word = bus.button_data;
            reply_len  = POLL_BITS;
        end else begin
            reply_word = {ID_REPLY, 8'h00};
            reply_len  = ID_BITS;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        tx_start     = 1'b0;
        tx_bit       = 1'b0;
        tx_stop_mode = 1'b0;
        load_reply   = 1'b0;
        shift_reply  = 1'b0;
        rx_enter     = 1'b0;
        rx_arm       = 1'b0;
        rx_sample    = 1'b0;
        stop_fall    = 1'b0;
        cmd_commit   = 1'b0;
        case (state)
            IDLE: begin
                if (fall) begin
                    rx_enter  = 1'b1;
                    state_nxt = RX_BITS;
                end
            end
            RX_BITS: begin
                if (timeout) begin
                    state_nxt = IDLE;
                end else if (bit_phase && (cnt == SAMPLE_AT)) begin
                    rx_sample = 1'b1;
                    if (rx_cnt == 3'd7) begin
                        state_nxt = RX_STOP;
                    end
                end else if (!bit_phase && fall) begin
                    rx_arm = 1'b1;
                end
            end
            RX_STOP: begin
                if (timeout) begin
                    state_nxt = IDLE;
                end else if (stop_seen && rise) begin
                    cmd_commit = 1'b1;
                    state_nxt  = TURNAROUND;
                end else if (fall) begin
                    stop_fall = 1'b1;
                end
            end
            TURNAROUND: begin
                if (cnt == TURN_LAST) begin
                    if (supported) begin
                        load_reply = 1'b1;
                        tx_start   = 1'b1;
                        tx_bit     = reply_word[31];
                        state_nxt  = TX;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            TX: begin
                if (tx_done) begin
                    tx_start = 1'b1;
                    if (tx_left > 6'd1) begin
                        shift_reply = 1'b1;
                        tx_bit      = tx_sr[31];
                    end else begin
                        tx_stop_mode = 1'b1;
                        state_nxt    = TX_STOP;
                    end
                end
            end
            TX_STOP: begin
                if (tx_done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Synchronizers reset high (idle line) so reset never fabricates a falling edge.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync1       <= 1'b1;
            sync2       <= 1'b1;
            sync_prev   <= 1'b1;
            cnt         <= '0;
            high_cnt    <= '0;
            bit_phase   <= 1'b0;
            rx_cnt      <= '0;
            rx_sr       <= '0;
            stop_seen   <= 1'b0;
            cmd_byte_q  <= '0;
            cmd_valid_q <= 1'b0;
            tx_sr       <= '0;
            tx_left     <= '0;
        end else begin
            sync1       <= bus.n64d_in;
            sync2       <= sync1;
            sync_prev   <= sync2;
            cmd_valid_q <= cmd_commit;

            if (rx_active && sync2) begin
                if (high_cnt != '1) high_cnt <= high_cnt + 1'b1;
            end else begin
                high_cnt <= '0;
            end

            if (rx_enter || rx_arm || cmd_commit) begin
                cnt <= '0;
            end else if (cnt != '1) begin
                cnt <= cnt + 1'b1;
            end

            if (rx_enter || rx_arm) begin
                bit_phase <= 1'b1;
            end else if (rx_sample) begin
                bit_phase <= 1'b0;
            end

            if (rx_enter) begin
                rx_cnt <= '0;
            end else if (rx_sample) begin
                rx_cnt <= rx_cnt + 1'b1;
            end

            if (rx_sample) begin
                rx_sr <= {rx_sr[6:0], sync2};
            end

            if (rx_enter || cmd_commit) begin
                stop_seen <= 1'b0;
            end else if (stop_fall) begin
                stop_seen <= 1'b1;
            end

            if (cmd_commit) begin
                cmd_byte_q <= rx_sr;
            end

            // tx_sr holds the bits still to send after the one in flight, MSB next.
            if (load_reply) begin
                tx_sr   <= reply_word << 1;
                tx_left <= reply_len;
            end else if (shift_reply) begin
                tx_sr   <= tx_sr << 1;
                tx_left <= tx_left - 1'b1;
            end
        end
    end

    n64_bit_tx #(
        .CYCLES_PER_US(CYCLES_PER_US)
    ) u_bit_tx (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .start    (tx_start),
        .bit_val  (tx_bit),
        .stop_mode(tx_stop_mode),
        .oe       (tx_oe),
        .done     (tx_done)
    );

    assign bus.n64d_oe   = tx_oe;
    assign bus.cmd_byte  = cmd_byte_q;
    assign bus.cmd_valid = cmd_valid_q;
    assign bus.tx_busy   = (state == TX) || (state == TX_STOP);

endmodule
